// File: rtl/csr_trap_sequencer_if.sv
// Bundle of signals between the trap/CSR sequencer, the pipeline and the CSR register file.
// The slave side is the sequencer. The master side is the pipeline plus the CSR file.
//
// Handshake: a CSR request transfers on a cycle where csr_req_valid and csr_req_ready are
// both high. csr_req_ready does not depend on csr_req_valid. The old CSR value comes back
// on csr_rsp_valid/csr_rsp_rdata exactly one cycle later. trap_valid and mret_valid have
// no ready signal: they are taken on any cycle the sequencer is idle, and ignored otherwise.
interface csr_trap_sequencer_if;
  logic        csr_req_valid;
  logic        csr_req_ready;
  logic [11:0] csr_req_addr;
  logic [1:0]  csr_req_op;
  logic        csr_req_wen;
  logic [31:0] csr_req_wdata;
  logic        csr_rsp_valid;
  logic [31:0] csr_rsp_rdata;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport slave (
    input  csr_req_valid, csr_req_addr, csr_req_op, csr_req_wen, csr_req_wdata,
    input  trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, csr_rdata,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, busy,
    output redirect_valid, redirect_pc, csr_addr, csr_we, csr_wdata
  );

  modport master (
    output csr_req_valid, csr_req_addr, csr_req_op, csr_req_wen, csr_req_wdata,
    output trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, csr_rdata,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, busy,
    input  redirect_valid, redirect_pc, csr_addr, csr_we, csr_wdata
  );
endinterface

// File: rtl/csr_trap_sequencer.sv
// Single owner of the CSR file port. Pipeline CSR instructions are serviced in one cycle
// from IDLE; trap entry and MRET run fixed multi-cycle sequences that end in a one-cycle
// fetch redirect. The pipeline is stalled through busy in every non-idle state.
module csr_trap_sequencer #(
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [1:0] MRET_MPP    = 2'b11
) (
  input  logic                       clk,
  input  logic                       rst,
  csr_trap_sequencer_if.slave        bus,
  output logic [3:0]                 state_dbg
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_TRAP_EPC   = 4'd1,
    S_TRAP_CAUSE = 4'd2,
    S_TRAP_TVAL  = 4'd3,
    S_TRAP_STAT  = 4'd4,
    S_TRAP_VEC   = 4'd5,
    S_MRET_EPC   = 4'd6,
    S_MRET_STAT  = 4'd7,
    S_REDIRECT   = 4'd8
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Trap operands captured on the accept cycle; the requester drops them afterwards.
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [31:0] target_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  // Last address/data put on the CSR port, so the port holds steady when idle.
  logic [11:0] addr_q;
  logic [31:0] wdata_q;

  logic        req_ready;
  logic        req_fire;
  logic        req_wr;
  logic [31:0] csr_new;
  logic [31:0] stat_trap;
  logic [31:0] stat_mret;
  logic [31:0] vec_base;
  logic [31:0] vec_target;
  logic [31:0] epc_read;

  logic        busy_c;
  logic        redirect_c;
  logic        we_c;
  logic [11:0] addr_c;
  logic [31:0] wdata_c;

  // Traps and MRET outrank pipeline requests; a reset cycle accepts nothing.
  assign req_ready = (state == S_IDLE) & ~bus.trap_valid & ~bus.mret_valid & ~rst;
  assign req_fire  = bus.csr_req_valid & req_ready;
  assign req_wr    = bus.csr_req_wen & (bus.csr_req_op != 2'b00);

  // New value for a pipeline CSR instruction, from the combinational read of the CSR file.
  always_comb begin
    csr_new = bus.csr_rdata;
    case (bus.csr_req_op)
      OP_RW:   csr_new = bus.csr_req_wdata;
      OP_RS:   csr_new = bus.csr_rdata | bus.csr_req_wdata;
      OP_RC:   csr_new = bus.csr_rdata & ~bus.csr_req_wdata;
      default: csr_new = bus.csr_rdata;
    endcase
  end

  // mstatus read-modify-write values for trap entry and MRET; all other bits pass through.
  always_comb begin
    stat_trap        = bus.csr_rdata;
    stat_trap[7]     = bus.csr_rdata[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;

    stat_mret        = bus.csr_rdata;
    stat_mret[3]     = bus.csr_rdata[7];
    stat_mret[7]     = 1'b1;
    stat_mret[12:11] = MRET_MPP;
  end

  // Trap vector: interrupts in vectored mode jump to base + 4*code, wrapping mod 2^32.
  always_comb begin
    vec_base   = bus.csr_rdata & ~32'h3;
    vec_target = vec_base;
    if (VECTORED_EN && (bus.csr_rdata[1:0] == 2'b01) && cause_q[31]) begin
      vec_target = vec_base + {cause_q[29:0], 2'b00};
    end
  end

  assign epc_read = bus.csr_rdata & ~32'h3;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed sequences, only IDLE looks at the requests.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.trap_valid) begin
          state_nxt = S_TRAP_EPC;
        end else if (bus.mret_valid) begin
          state_nxt = S_MRET_EPC;
        end
      end
      S_TRAP_EPC:   state_nxt = S_TRAP_CAUSE;
      S_TRAP_CAUSE: state_nxt = S_TRAP_TVAL;
      S_TRAP_TVAL:  state_nxt = S_TRAP_STAT;
      S_TRAP_STAT:  state_nxt = S_TRAP_VEC;
      S_TRAP_VEC:   state_nxt = S_REDIRECT;
      S_MRET_EPC:   state_nxt = S_MRET_STAT;
      S_MRET_STAT:  state_nxt = S_REDIRECT;
      S_REDIRECT:   state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Output logic: CSR port control per state, redirect pulse and stall.
  always_comb begin
    busy_c     = (state != S_IDLE);
    redirect_c = 1'b0;
    we_c       = 1'b0;
    addr_c     = addr_q;
    wdata_c    = wdata_q;
    case (state)
      S_IDLE: begin
        if (req_fire) begin
          addr_c = bus.csr_req_addr;
          if (req_wr) begin
            we_c    = 1'b1;
            wdata_c = csr_new;
          end
        end
      end
      S_TRAP_EPC: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MEPC;
        wdata_c = epc_q;
      end
      S_TRAP_CAUSE: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MCAUSE;
        wdata_c = cause_q;
      end
      S_TRAP_TVAL: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MTVAL;
        wdata_c = tval_q;
      end
      S_TRAP_STAT: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MSTATUS;
        wdata_c = stat_trap;
      end
      S_TRAP_VEC: begin
        addr_c = ADDR_MTVEC;
      end
      S_MRET_EPC: begin
        addr_c = ADDR_MEPC;
      end
      S_MRET_STAT: begin
        we_c    = 1'b1;
        addr_c  = ADDR_MSTATUS;
        wdata_c = stat_mret;
      end
      S_REDIRECT: begin
        redirect_c = 1'b1;
      end
      default: begin
        busy_c = 1'b1;
      end
    endcase
    // A reset cycle aborts the sequence: no further write and no redirect.
    if (rst) begin
      we_c       = 1'b0;
      redirect_c = 1'b0;
    end
  end

  // Datapath registers: operand capture, target, CSR response and port hold values.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q       <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      target_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= req_fire;
      if (req_fire) begin
        rsp_rdata_q <= bus.csr_rdata;
      end
      if ((state == S_IDLE) && bus.trap_valid) begin
        epc_q   <= bus.trap_pc & ~32'h3;
        cause_q <= bus.trap_cause;
        tval_q  <= bus.trap_tval;
      end
      if (state == S_TRAP_VEC) begin
        target_q <= vec_target;
      end
      if (state == S_MRET_EPC) begin
        target_q <= epc_read;
      end
      addr_q  <= addr_c;
      wdata_q <= wdata_c;
    end
  end

  assign bus.csr_req_ready  = req_ready;
  assign bus.csr_rsp_valid  = rsp_valid_q;
  assign bus.csr_rsp_rdata  = rsp_rdata_q;
  assign bus.busy           = busy_c;
  assign bus.redirect_valid = redirect_c;
  assign bus.redirect_pc    = target_q;
  assign bus.csr_addr       = addr_c;
  assign bus.csr_we         = we_c;
  assign bus.csr_wdata      = wdata_c;
  assign state_dbg          = state;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: a CSR register file around the DUT, a reference model of
// the architectural effects (CSR values, write order, redirect targets) and random traffic.
module tb_csr_trap_sequencer;

  localparam bit         VEC_EN = 1'b1;
  localparam logic [1:0] MPP    = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_trap_sequencer_if bus ();
  logic [3:0] state_dbg;

  csr_trap_sequencer #(
    .VECTORED_EN (VEC_EN),
    .MRET_MPP    (MPP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- CSR register file (environment) ----------------
  logic [31:0] csr_mem [4096];
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;

  assign bus.csr_rdata = csr_mem[bus.csr_addr];

  always @(posedge clk) begin
    if (load_en) csr_mem[load_addr] <= load_data;
    else if (bus.csr_we) csr_mem[bus.csr_addr] <= bus.csr_wdata;
  end

  // ---------------- reference model state / scoreboard ----------------
  logic [31:0] ref_csr [4096];
  logic [31:0] exp_q[$];
  logic [11:0] addr_tab [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h340};
  int n_cmp = 0;
  int n_err = 0;

  // Expected CSR writes per sequence cycle (index = cycles after accept).
  logic        seq_we   [8];
  logic [11:0] seq_addr [8];
  logic [31:0] seq_wd   [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pick_addr();
    return addr_tab[$urandom_range(0, 5)];
  endfunction

  function automatic logic [31:0] model_csr(input logic [1:0] op, input logic [31:0] old,
                                            input logic [31:0] wd);
    if (op == 2'd1) return wd;
    if (op == 2'd2) return old | wd;
    if (op == 2'd3) return old & ~wd;
    return old;
  endfunction

  function automatic logic [31:0] model_trap_mstatus(input logic [31:0] old);
    logic [31:0] mie;
    mie = (old >> 3) & 32'h1;
    return (old & ~32'h1888) | 32'h1800 | (mie << 7);
  endfunction

  function automatic logic [31:0] model_mret_mstatus(input logic [31:0] old);
    logic [31:0] mpie;
    mpie = (old >> 7) & 32'h1;
    return (old & ~32'h1888) | (32'(MPP) << 11) | 32'h80 | (mpie << 3);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & ~32'h3;
    if (VEC_EN && ((mtvec & 32'h3) == 32'h1) && (cause >= 32'h8000_0000))
      return base + (cause & 32'h3FFF_FFFF) * 32'd4;
    return base;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.trap_valid    = 1'b0;
    bus.mret_valid    = 1'b0;
    bus.csr_req_valid = 1'b0;
  endtask

  task automatic drive_noise_req();
    bus.csr_req_valid = 1'($urandom_range(0, 1));
    bus.csr_req_addr  = pick_addr();
    bus.csr_req_op    = 2'($urandom_range(0, 3));
    bus.csr_req_wen   = 1'($urandom_range(0, 1));
    bus.csr_req_wdata = $urandom;
  endtask

  task automatic load_csr(input logic [11:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    ref_csr[a] = d;
    @(negedge clk);
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // One accepted CSR instruction; also checks the response of the previous beat.
  task automatic csr_beat(input logic [11:0] a, input logic [1:0] op, input logic wen,
                          input logic [31:0] wd, input bit first);
    logic [31:0] old, nv;
    logic dw;
    old = ref_csr[a];
    nv  = model_csr(op, old, wd);
    dw  = wen && (op != 2'd0);
    bus.csr_req_valid = 1'b1;
    bus.csr_req_addr  = a;
    bus.csr_req_op    = op;
    bus.csr_req_wen   = wen;
    bus.csr_req_wdata = wd;
    @(negedge clk);
    check_eq("req_ready", 32'(bus.csr_req_ready), 32'd1);
    check_eq("req_we", 32'(bus.csr_we), 32'(dw));
    check_eq("req_addr", 32'(bus.csr_addr), 32'(a));
    if (dw) check_eq("req_wdata", bus.csr_wdata, nv);
    if (first) begin
      check_eq("rsp_idle", 32'(bus.csr_rsp_valid), 32'd0);
    end else begin
      check_eq("rsp_valid", 32'(bus.csr_rsp_valid), 32'd1);
      check_eq("rsp_rdata", bus.csr_rsp_rdata, exp_q.pop_front());
    end
    exp_q.push_back(old);
    if (dw) ref_csr[a] = nv;
    @(posedge clk); #1;
  endtask

  task automatic csr_drain();
    bus.csr_req_valid = 1'b0;
    @(negedge clk);
    check_eq("rsp_valid", 32'(bus.csr_rsp_valid), 32'd1);
    check_eq("rsp_rdata", bus.csr_rsp_rdata, exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic csr_burst(input int n);
    for (int i = 0; i < n; i++)
      csr_beat(pick_addr(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, i == 0);
    csr_drain();
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 8; i++) begin
      seq_we[i]   = 1'b0;
      seq_addr[i] = '0;
      seq_wd[i]   = '0;
    end
  endtask

  // Cycles 1..len of a trap/MRET sequence, then the idle cycle that follows.
  task automatic run_seq(input int len, input logic [31:0] tgt, input bit noise);
    for (int k = 1; k <= len; k++) begin
      if (noise) begin
        bus.trap_valid = 1'($urandom_range(0, 1));
        bus.mret_valid = 1'($urandom_range(0, 1));
        drive_noise_req();
      end
      @(negedge clk);
      check_eq("seq_busy", 32'(bus.busy), 32'd1);
      check_eq("seq_ready", 32'(bus.csr_req_ready), 32'd0);
      check_eq("seq_we", 32'(bus.csr_we), 32'(seq_we[k]));
      if (seq_we[k]) begin
        check_eq("seq_addr", 32'(bus.csr_addr), 32'(seq_addr[k]));
        check_eq("seq_wdata", bus.csr_wdata, seq_wd[k]);
      end
      check_eq("redir_valid", 32'(bus.redirect_valid), 32'(k == len));
      if (k == len) check_eq("redir_pc", bus.redirect_pc, tgt);
      @(posedge clk); #1;
    end
    drive_idle();
    @(negedge clk);
    check_eq("post_busy", 32'(bus.busy), 32'd0);
    check_eq("post_redir", 32'(bus.redirect_valid), 32'd0);
    check_eq("post_we", 32'(bus.csr_we), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic trap_accept(input logic [31:0] cause, input logic [31:0] pc,
                             input logic [31:0] tval, input bit noise);
    bus.trap_valid = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
    if (noise) begin
      bus.mret_valid = 1'b1;
      drive_noise_req();
      bus.csr_req_valid = 1'b1;
    end
    @(negedge clk);
    check_eq("acc_busy", 32'(bus.busy), 32'd0);
    check_eq("acc_ready", 32'(bus.csr_req_ready), 32'd0);
    check_eq("acc_we", 32'(bus.csr_we), 32'd0);
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input bit noise);
    logic [31:0] st_new, tgt;
    st_new = model_trap_mstatus(ref_csr[12'h300]);
    tgt    = model_target(ref_csr[12'h305], cause);
    clear_seq();
    seq_we[1] = 1'b1; seq_addr[1] = 12'h341; seq_wd[1] = pc & ~32'h3;
    seq_we[2] = 1'b1; seq_addr[2] = 12'h342; seq_wd[2] = cause;
    seq_we[3] = 1'b1; seq_addr[3] = 12'h343; seq_wd[3] = tval;
    seq_we[4] = 1'b1; seq_addr[4] = 12'h300; seq_wd[4] = st_new;
    trap_accept(cause, pc, tval, noise);
    run_seq(6, tgt, noise);
    ref_csr[12'h341] = pc & ~32'h3;
    ref_csr[12'h342] = cause;
    ref_csr[12'h343] = tval;
    ref_csr[12'h300] = st_new;
  endtask

  task automatic do_mret(input bit noise);
    logic [31:0] st_new, tgt;
    st_new = model_mret_mstatus(ref_csr[12'h300]);
    tgt    = ref_csr[12'h341] & ~32'h3;
    clear_seq();
    seq_we[2] = 1'b1; seq_addr[2] = 12'h300; seq_wd[2] = st_new;
    bus.mret_valid = 1'b1;
    if (noise) begin
      drive_noise_req();
      bus.csr_req_valid = 1'b1;
    end
    @(negedge clk);
    check_eq("mret_acc_busy", 32'(bus.busy), 32'd0);
    check_eq("mret_acc_ready", 32'(bus.csr_req_ready), 32'd0);
    check_eq("mret_acc_we", 32'(bus.csr_we), 32'd0);
    @(posedge clk); #1;
    drive_idle();
    run_seq(3, tgt, noise);
    ref_csr[12'h300] = st_new;
  endtask

  // Reset while the trap sequence sits in its mtval step.
  task automatic reset_mid_trap();
    logic [31:0] st_old, pc, cause;
    st_old = ref_csr[12'h300];
    pc     = 32'h0000_4006;
    cause  = 32'h0000_000B;
    trap_accept(cause, pc, 32'h1234_5678, 1'b0);
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_redir", 32'(bus.redirect_valid), 32'd0);
      check_eq("rst_we", 32'(bus.csr_we), 32'd0);
      @(posedge clk); #1;
    end
    check_eq("rst_mepc", csr_mem[12'h341], pc & ~32'h3);
    check_eq("rst_mcause", csr_mem[12'h342], cause);
    check_eq("rst_mstatus", csr_mem[12'h300], st_old);
    ref_csr[12'h341] = pc & ~32'h3;
    ref_csr[12'h342] = cause;
    load_csr(12'h343, ref_csr[12'h343]);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] cause;
    rst = 1'b1;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    drive_idle();
    bus.csr_req_addr = '0; bus.csr_req_op = '0; bus.csr_req_wen = 1'b0; bus.csr_req_wdata = '0;
    bus.trap_cause = '0; bus.trap_pc = '0; bus.trap_tval = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) load_csr(addr_tab[i], $urandom);
    rst = 1'b0;

    // Reset values.
    @(negedge clk);
    check_eq("rst_busy0", 32'(bus.busy), 32'd0);
    check_eq("rst_redir0", 32'(bus.redirect_valid), 32'd0);
    check_eq("rst_rspv0", 32'(bus.csr_rsp_valid), 32'd0);
    check_eq("rst_we0", 32'(bus.csr_we), 32'd0);
    check_eq("rst_rdata0", bus.csr_rsp_rdata, 32'd0);
    check_eq("rst_rpc0", bus.redirect_pc, 32'd0);
    check_eq("rst_addr0", 32'(bus.csr_addr), 32'd0);
    check_eq("rst_wdata0", bus.csr_wdata, 32'd0);
    @(posedge clk); #1;

    // CSRRS on mstatus.
    load_csr(12'h300, 32'h0000_1800);
    csr_beat(12'h300, 2'b10, 1'b1, 32'h8, 1'b1);
    csr_drain();

    // Exception entry, direct mode.
    load_csr(12'h300, 32'h0000_0008);
    load_csr(12'h305, 32'h0000_0100);
    do_trap(32'h2, 32'h1002, 32'hDEAD, 1'b0);

    // Interrupt entry, vectored mode.
    load_csr(12'h305, 32'h0000_0101);
    do_trap(32'h8000_0007, 32'h0000_3000, 32'h0, 1'b0);

    // Vector offset wrapping past 2^32.
    load_csr(12'h305, 32'hFFFF_FF01);
    do_trap(32'h8000_0010, 32'h0000_5000, 32'h0, 1'b0);

    // MRET.
    load_csr(12'h341, 32'h0000_2000);
    load_csr(12'h300, 32'h0000_1880);
    do_mret(1'b0);

    // All three requests together, then noise while busy.
    do_trap(32'h5, 32'h0000_7777, 32'hBEEF, 1'b1);
    do_mret(1'b1);

    reset_mid_trap();

    // Random mix.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: csr_burst($urandom_range(1, 5));
        1: begin
          cause = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | $urandom_range(0, 15))
                                              : $urandom_range(0, 15);
          do_trap(cause, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        2: do_mret(1'($urandom_range(0, 1)));
        default: begin
          load_csr(12'h305, ($urandom & ~32'h3) | $urandom_range(0, 3));
          do_trap(32'h8000_0000 | $urandom_range(0, 31), $urandom, $urandom,
                  1'($urandom_range(0, 1)));
        end
      endcase
    end

    // Final architectural state of the CSR file.
    for (int i = 0; i < 6; i++) check_eq("final_csr", csr_mem[addr_tab[i]], ref_csr[addr_tab[i]]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
